fpu_mul_scheduler: RTL and testbench

FPU_MUL_SCHEDULER -- requirements
Module: fpu_mul_scheduler

---
 rtl/fpu_mul_scheduler_pkg.sv | 25 ++
 rtl/fpu_mul_scheduler_rr_arbiter.sv | 56 +++++
 rtl/fpu_mul_scheduler.sv | 156 +++++++++++++++
 tb/tb_fpu_mul_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_mul_scheduler_pkg.sv
// ============================================================================
// Module   : fpu_mul_scheduler_pkg
// Brief    : Shared defaults, widths and helpers for the FP32 multiply scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_mul_scheduler_pkg;

    localparam int NREQ_DEFAULT      = 4;
    localparam int LAT_DEFAULT       = 3;
    localparam int MAX_OUTST_DEFAULT = 2;

    // Wide enough for MAX_OUTST up to 3.
    localparam int CNT_W = 2;

    typedef logic [CNT_W-1:0] outst_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_mul_scheduler_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin single-grant arbiter; pointer advances past an accepted grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import fpu_mul_scheduler_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] eligible,
    input  logic            accept,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id
);

    logic [ID_W-1:0] ptr;
    logic            found;

    // Two passes: indices at/after the pointer first, then the wrapped ones.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && eligible[i] && (i >= int'(ptr))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                grant_id = ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && eligible[i] && (i < int'(ptr))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                grant_id = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_mul_scheduler.sv
// ============================================================================
// Module   : fpu_mul_scheduler
// Brief    : Shares one fixed-latency FP32 multiplier among NREQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_mul_scheduler
    import fpu_mul_scheduler_pkg::*;
#(
    parameter int NREQ      = NREQ_DEFAULT,
    parameter int LAT       = LAT_DEFAULT,
    parameter int MAX_OUTST = MAX_OUTST_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_en,
    input  logic [NREQ-1:0]    io_req_valid,
    output logic [NREQ-1:0]    io_req_ready,
    input  logic [32*NREQ-1:0] io_req_a,
    input  logic [32*NREQ-1:0] io_req_b,
    output logic               io_dp_valid,
    output logic [31:0]        io_dp_a,
    output logic [31:0]        io_dp_b,
    input  logic [31:0]        io_dp_res,
    output logic [NREQ-1:0]    io_resp_valid,
    output logic [31:0]        io_resp_data,
    output logic               io_busy
);

    localparam int ID_W = id_width(NREQ);

    outst_t            outst [NREQ];
    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   grant_id;
    logic              accept;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    logic [ID_W-1:0]   dp_id;
    logic [LAT-1:0]    sr_valid;
    logic [ID_W-1:0]   sr_id [LAT];
    logic              head_valid;
    logic [ID_W-1:0]   head_id;
    logic [NREQ-1:0]   resp_hit;
    logic [NREQ-1:0]   nonzero;

    // Eligibility already folds in io_req_valid, so any grant is an accept.
    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_elig
            assign eligible[i] = io_en & io_req_valid[i] & (outst[i] < CNT_W'(MAX_OUTST));
            assign nonzero[i]  = |outst[i];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .clock    (clock),
        .reset    (reset),
        .eligible (eligible),
        .accept   (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign accept       = |grant;
    assign io_req_ready = grant;
    assign io_busy      = |nonzero;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = io_req_a[i*32 +: 32];
                sel_b = io_req_b[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_dp_valid <= 1'b0;
            io_dp_a     <= '0;
            io_dp_b     <= '0;
            dp_id       <= '0;
        end else begin
            io_dp_valid <= accept;
            if (accept) begin
                io_dp_a <= sel_a;
                io_dp_b <= sel_b;
                dp_id   <= grant_id;
            end
        end
    end

    // Tag pipeline: head lines up with io_dp_res LAT cycles after issue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sr_valid <= '0;
            for (int i = 0; i < LAT; i++) begin
                sr_id[i] <= '0;
            end
        end else begin
            sr_valid[0] <= io_dp_valid;
            sr_id[0]    <= dp_id;
            for (int i = 1; i < LAT; i++) begin
                sr_valid[i] <= sr_valid[i-1];
                sr_id[i]    <= sr_id[i-1];
            end
        end
    end

    assign head_valid = sr_valid[LAT-1];
    assign head_id    = sr_id[LAT-1];

    always_comb begin
        resp_hit = '0;
        for (int i = 0; i < NREQ; i++) begin
            resp_hit[i] = head_valid && (head_id == ID_W'(i));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_resp_valid <= '0;
            io_resp_data  <= '0;
        end else begin
            io_resp_valid <= resp_hit;
            if (head_valid) begin
                io_resp_data <= io_dp_res;
            end
        end
    end

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_cnt
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    outst[i] <= '0;
                end else begin
                    case ({grant[i], io_resp_valid[i]})
                        2'b10:   outst[i] <= outst[i] + 1'b1;
                        2'b01:   outst[i] <= outst[i] - 1'b1;
                        default: outst[i] <= outst[i];
                    endcase
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fpu_mul_scheduler.sv
// ============================================================================
// Module   : tb_fpu_mul_scheduler
// Brief    : Self-checking bench for fpu_mul_scheduler with a cycle-level scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_mul_scheduler;

    localparam int NREQ      = 4;
    localparam int LAT       = 3;
    localparam int MAX_OUTST = 2;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               io_en = 1'b0;
    logic [NREQ-1:0]    io_req_valid = '0;
    logic [NREQ-1:0]    io_req_ready;
    logic [32*NREQ-1:0] io_req_a = '0;
    logic [32*NREQ-1:0] io_req_b = '0;
    logic               io_dp_valid;
    logic [31:0]        io_dp_a;
    logic [31:0]        io_dp_b;
    logic [31:0]        io_dp_res = '0;
    logic [NREQ-1:0]    io_resp_valid;
    logic [31:0]        io_resp_data;
    logic               io_busy;

    fpu_mul_scheduler #(
        .NREQ      (NREQ),
        .LAT       (LAT),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_en         (io_en),
        .io_req_valid  (io_req_valid),
        .io_req_ready  (io_req_ready),
        .io_req_a      (io_req_a),
        .io_req_b      (io_req_b),
        .io_dp_valid   (io_dp_valid),
        .io_dp_a       (io_dp_a),
        .io_dp_b       (io_dp_b),
        .io_dp_res     (io_dp_res),
        .io_resp_valid (io_resp_valid),
        .io_resp_data  (io_resp_data),
        .io_busy       (io_busy)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Scoreboard state: what the scheduler should be doing, per the rules.
    int          m_ptr;
    int          m_cnt [NREQ];
    bit          m_prev_acc;
    logic [31:0] m_dp_a, m_dp_b;
    int          rv_id   [int];
    logic [31:0] rv_data [int];
    logic [31:0] dpres   [int];

    typedef struct {
        bit              en;
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] exp_ready;
    } vec_t;

    // Stand-in datapath: truncating FP32 multiply for normal operands.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], 8'(e), m};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr      = 0;
        m_prev_acc = 0;
        m_dp_a     = '0;
        m_dp_b     = '0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        rv_id.delete();
        rv_data.delete();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_dp_valid"}, 32'(io_dp_valid), 32'd0);
        chk({name, "_dp_a"}, io_dp_a, 32'd0);
        chk({name, "_dp_b"}, io_dp_b, 32'd0);
        chk({name, "_resp_valid"}, 32'(io_resp_valid), 32'd0);
        chk({name, "_resp_data"}, io_resp_data, 32'd0);
        chk({name, "_busy"}, 32'(io_busy), 32'd0);
    endtask

    // One clock cycle: check at negedge against the model, then advance it.
    task automatic step(output logic [NREQ-1:0] seen);
        int              g;
        bit              busy_exp;
        logic [NREQ-1:0] er;
        logic [NREQ-1:0] erv;
        logic [31:0]     prod;
        @(negedge clock);
        g = -1;
        if (reset && io_en) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (g < 0 && io_req_valid[i] && m_cnt[i] < MAX_OUTST) g = i;
            end
        end
        er       = (g >= 0) ? NREQ'(1 << g) : '0;
        erv      = rv_id.exists(cyc) ? NREQ'(1 << rv_id[cyc]) : '0;
        busy_exp = 0;
        for (int i = 0; i < NREQ; i++) if (m_cnt[i] != 0) busy_exp = 1;
        seen = io_req_ready;
        chk("ready", 32'(io_req_ready), 32'(er));
        chk("dp_valid", 32'(io_dp_valid), 32'(m_prev_acc));
        chk("dp_a", io_dp_a, m_dp_a);
        chk("dp_b", io_dp_b, m_dp_b);
        chk("resp_valid", 32'(io_resp_valid), 32'(erv));
        if (erv != '0) chk("resp_data", io_resp_data, rv_data[cyc]);
        chk("busy", 32'(io_busy), 32'(busy_exp));
        if (reset) begin
            if (erv != '0) begin
                m_cnt[rv_id[cyc]]--;
                rv_id.delete(cyc);
                rv_data.delete(cyc);
            end
            if (g >= 0) begin
                m_cnt[g]++;
                m_ptr  = (g + 1) % NREQ;
                m_dp_a = io_req_a[g*32 +: 32];
                m_dp_b = io_req_b[g*32 +: 32];
                prod   = fmul(m_dp_a, m_dp_b);
                rv_id[cyc + 2 + LAT]   = g;
                rv_data[cyc + 2 + LAT] = prod;
                dpres[cyc + 1 + LAT]   = prod;
            end
            m_prev_acc = (g >= 0);
        end else begin
            m_prev_acc = 0;
        end
        io_dp_res = dpres.exists(cyc) ? dpres[cyc] : $urandom;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic [NREQ-1:0] s;
        io_req_valid = '0;
        for (int i = 0; i < n; i++) step(s);
    endtask

    task automatic pulse_reset();
        io_req_valid = '0;
        reset = 1'b0;
        #1;
        model_reset();
        chk_all_zero("reset");
        idle(2);
        reset = 1'b1;
    endtask

    vec_t            vecs [11];
    logic [NREQ-1:0] seen;
    int              n_acc;
    int              n_resp;
    int              n_rdy;

    initial begin
        model_reset();
        #1;
        chk_all_zero("por");
        idle(2);
        reset = 1'b1;

        // Single op from requester 1 at relative cycle 5.
        io_en = 1'b1;
        for (int t = 0; t < 12; t++) begin
            if (t == 6) begin
                chk("single_dp_valid", 32'(io_dp_valid), 32'd1);
                chk("single_dp_a", io_dp_a, 32'h3F80_0000);
                chk("single_dp_b", io_dp_b, 32'h4000_0000);
            end
            if (t == 5 + 2 + LAT) begin
                chk("single_resp_valid", 32'(io_resp_valid), 32'b0010);
                chk("single_resp_data", io_resp_data, 32'h4000_0000);
            end
            io_req_valid = (t == 5) ? 4'b0010 : 4'b0000;
            io_req_a[63:32] = 32'h3F80_0000;
            io_req_b[63:32] = 32'h4000_0000;
            step(seen);
        end

        // Fairness and gating table, starting from a fresh reset.
        pulse_reset();
        vecs[0]  = '{1'b1, 4'b1111, 4'b0001};
        vecs[1]  = '{1'b1, 4'b1111, 4'b0010};
        vecs[2]  = '{1'b1, 4'b1111, 4'b0100};
        vecs[3]  = '{1'b1, 4'b1111, 4'b1000};
        vecs[4]  = '{1'b1, 4'b1111, 4'b0001};
        vecs[5]  = '{1'b1, 4'b1111, 4'b0010};
        vecs[6]  = '{1'b1, 4'b1111, 4'b0100};
        vecs[7]  = '{1'b1, 4'b1111, 4'b1000};
        vecs[8]  = '{1'b0, 4'b1111, 4'b0000};
        vecs[9]  = '{1'b1, 4'b0001, 4'b0001};
        vecs[10] = '{1'b1, 4'b0000, 4'b0000};
        for (int v = 0; v < 11; v++) begin
            io_en        = vecs[v].en;
            io_req_valid = vecs[v].valid;
            io_req_a     = {$urandom, $urandom, $urandom, $urandom};
            io_req_b     = {$urandom, $urandom, $urandom, $urandom};
            step(seen);
            chk("table_ready", 32'(seen), 32'(vecs[v].exp_ready));
        end
        io_en = 1'b1;
        idle(10);

        // Outstanding limit: requester 0 alone.
        n_acc = 0;
        for (int t = 0; t < 14; t++) begin
            io_req_valid = 4'b0001;
            io_req_a[31:0] = $urandom;
            io_req_b[31:0] = $urandom;
            step(seen);
            if (t < 6 && seen[0]) n_acc++;
        end
        chk("outst_first6", 32'(n_acc), 32'd2);
        idle(10);

        // Disable with three operations in flight.
        for (int t = 0; t < 3; t++) begin
            io_req_valid = 4'b1111;
            step(seen);
        end
        io_en  = 1'b0;
        n_resp = 0;
        n_rdy  = 0;
        for (int t = 0; t < 10; t++) begin
            io_req_valid = 4'b1111;
            step(seen);
            if (seen != '0) n_rdy++;
            n_resp += $countones(io_resp_valid);
        end
        chk("drain_ready", 32'(n_rdy), 32'd0);
        chk("drain_resp", 32'(n_resp), 32'd3);
        chk("drain_busy", 32'(io_busy), 32'd0);
        io_en = 1'b1;

        // Reset with two operations in flight.
        for (int t = 0; t < 2; t++) begin
            io_req_valid = 4'b1111;
            step(seen);
        end
        #2;
        pulse_reset();
        io_req_valid = 4'b1100;
        step(seen);
        chk("post_reset_grant", 32'(seen), 32'b0100);
        idle(10);

        // Simultaneous accept and response on requester 2.
        io_req_valid = 4'b0100;
        step(seen);
        idle(4);
        io_req_valid = 4'b0100;
        step(seen);
        chk("simul_ready", 32'(seen), 32'b0100);
        step(seen);
        chk("simul_next_ready", 32'(seen), 32'b0100);
        idle(10);

        // Random traffic against the scoreboard.
        for (int t = 0; t < 400; t++) begin
            io_en        = ($urandom_range(0, 7) != 0);
            io_req_valid = NREQ'($urandom);
            io_req_a     = {$urandom, $urandom, $urandom, $urandom};
            io_req_b     = {$urandom, $urandom, $urandom, $urandom};
            step(seen);
        end
        io_en = 1'b0;
        idle(15);
        chk("final_busy", 32'(io_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
